// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive datapath.
// Holds the legal oversampling ratios, the default frame length and the 2-of-3 voter.
package uart_rx_pkg;

  localparam int PRESCALE_8         = 8;
  localparam int PRESCALE_16        = 16;
  localparam int PRESCALE_32        = 32;
  localparam int FRAME_BITS_DEFAULT = 11;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rx_edge_bit_counter.sv
// Oversample-edge and bit-index counters for one UART frame.
// Both counters sit at zero while enable is low and wrap on the last edge of the last bit.
module rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] p_eff,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  frame_done
);

  logic [PRESCALE_W-1:0] edge_q, edge_d, p_last;
  logic [3:0]            bit_q, bit_d;
  logic                  edge_wrap, bit_last;

  assign p_last    = p_eff - PRESCALE_W'(1);
  // ">=" rather than "==" so a ratio shrunk mid-frame still wraps instead of running away.
  assign edge_wrap = (edge_q >= p_last);
  assign bit_last  = (bit_q >= 4'(FRAME_BITS - 1));

  always_comb begin
    edge_d = edge_q;
    bit_d  = bit_q;
    if (!enable) begin
      edge_d = '0;
      bit_d  = '0;
    end else if (edge_wrap) begin
      edge_d = '0;
      bit_d  = bit_last ? 4'd0 : bit_q + 4'd1;
    end else begin
      edge_d = edge_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_q <= '0;
      bit_q  <= '0;
    end else begin
      edge_q <= edge_d;
      bit_q  <= bit_d;
    end
  end

  assign edge_cnt   = edge_q;
  assign bit_cnt    = bit_q;
  assign frame_done = enable & (edge_q == p_last) & (bit_q == 4'(FRAME_BITS - 1));

endmodule

// File: rtl/rx_sample_timer.sv
// UART receive sample timer: synchronizes RX_IN, tracks oversample/bit position and
// majority-votes three mid-bit samples into one sampled_bit per bit period.
module rx_sample_timer
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  enable,
  output logic                  sampled_bit,
  output logic                  sample_valid,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  frame_done,
  output logic                  prescale_err
);

  // sample_valid is a one-cycle strobe with no back-pressure; sampled_bit is valid while
  // it is high and then holds its value until the next strobe.
  logic                  prescale_legal;
  logic [PRESCALE_W-1:0] p_eff, p_half;
  logic                  sync1_q, rx_s_q;
  logic                  s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;

  assign prescale_legal = (prescale == PRESCALE_W'(PRESCALE_8))  ||
                          (prescale == PRESCALE_W'(PRESCALE_16)) ||
                          (prescale == PRESCALE_W'(PRESCALE_32));
  assign p_eff          = prescale_legal ? prescale : PRESCALE_W'(PRESCALE_8);
  assign p_half         = p_eff >> 1;
  assign prescale_err   = enable & ~prescale_legal;

  rx_edge_bit_counter #(
    .PRESCALE_W (PRESCALE_W),
    .FRAME_BITS (FRAME_BITS)
  ) u_counter (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .p_eff      (p_eff),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .frame_done (frame_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= RX_IN;
      rx_s_q  <= sync1_q;
    end
  end

  always_comb begin
    s0_d           = s0_q;
    s1_d           = s1_q;
    s2_d           = s2_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    if (!enable) begin
      s0_d = 1'b1;
      s1_d = 1'b1;
      s2_d = 1'b1;
    end else begin
      if (edge_cnt == p_half - PRESCALE_W'(1)) s0_d = rx_s_q;
      if (edge_cnt == p_half)                  s1_d = rx_s_q;
      // Vote on the live third sample so the result is visible at edge P/2+2.
      if (edge_cnt == p_half + PRESCALE_W'(1)) begin
        s2_d           = rx_s_q;
        sampled_bit_d  = majority3(s0_q, s1_q, rx_s_q);
        sample_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s0_q           <= 1'b1;
      s1_q           <= 1'b1;
      s2_q           <= 1'b1;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
    end else begin
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  assign sampled_bit  = sampled_bit_q;
  assign sample_valid = sample_valid_q;

endmodule

// File: tb/tb_rx_sample_timer.sv
// Bench for rx_sample_timer: run-length reference model feeding an expected-sample queue,
// an independent monitor popping it, plus directed checks for the documented scenarios.
module tb_rx_sample_timer;

  localparam int PW   = 6;
  localparam int FB   = 11;
  localparam int HIST = 16384;

  logic          CLK = 1'b0;
  logic          RST, RX_IN, enable;
  logic [PW-1:0] prescale;
  logic          sampled_bit, sample_valid, frame_done, prescale_err;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;

  int          vectors     = 0;
  int          miscompares = 0;
  int          cyc         = 0;
  int          run         = 0;
  bit          lock_phase  = 1'b0;
  logic        rx_hist [HIST];
  logic [32:0] exp_q[$];

  rx_sample_timer #(.PRESCALE_W(PW), .FRAME_BITS(FB)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .prescale     (prescale),
    .enable       (enable),
    .sampled_bit  (sampled_bit),
    .sample_valid (sample_valid),
    .edge_cnt     (edge_cnt),
    .bit_cnt      (bit_cnt),
    .frame_done   (frame_done),
    .prescale_err (prescale_err)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time expired, required finish before 1000000");
    $fatal(1);
  end

  // ---------------- helpers ----------------
  function automatic bit is_legal(input int v);
    return (v == 8) || (v == 16) || (v == 32);
  endfunction

  function automatic int eff_p(input int v);
    return is_legal(v) ? v : 8;
  endfunction

  function automatic logic rx_at(input int i);
    if (i < 0) return 1'b1;
    return rx_hist[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: cycle %0d got %0d, required %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- reference model ----------------
  // edge/bit position follows from the length of the enabled run before this cycle.
  always @(negedge CLK) begin
    int   p, e_edge, e_bit, ones;
    logic v;
    if (!RST) begin
      run = 0;
      if (cyc < HIST) rx_hist[cyc] = 1'b1;
    end else begin
      if (cyc < HIST) rx_hist[cyc] = RX_IN;
      p      = eff_p(int'(prescale));
      e_edge = run % p;
      e_bit  = (run / p) % FB;
      if (!lock_phase) begin
        chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
        chk("bit_cnt", 32'(bit_cnt), 32'(e_bit));
        chk("frame_done", 32'(frame_done),
            32'(enable && e_edge == p - 1 && e_bit == FB - 1));
        chk("prescale_err", 32'(prescale_err), 32'(enable && !is_legal(int'(prescale))));
        if (enable && e_edge == p / 2 + 1) begin
          ones = int'(rx_at(cyc - 4)) + int'(rx_at(cyc - 3)) + int'(rx_at(cyc - 2));
          v    = (ones >= 2);
          exp_q.push_back({32'(cyc + 1), v});
        end
      end
      run = enable ? run + 1 : 0;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge CLK) begin
    logic [32:0] head;
    if (RST) begin
      while (exp_q.size() > 0 && int'(exp_q[0][32:1]) < cyc) begin
        head = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL sample_missing: no sample_valid at cycle %0d, required pulse with bit %0d",
                 int'(head[32:1]), head[0]);
      end
      if (sample_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sample_unexpected: got sample_valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          head = exp_q.pop_front();
          if (int'(head[32:1]) != cyc || head[0] !== sampled_bit) begin
            miscompares++;
            $display("FAIL sample: got bit %0d at cycle %0d, required bit %0d at cycle %0d",
                     sampled_bit, cyc, head[0], int'(head[32:1]));
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    int np, nfd, fd_r, pe, len;
    logic lvl;
    for (int i = 0; i < HIST; i++) rx_hist[i] = 1'b1;
    RST = 1'b0; enable = 1'b0; RX_IN = 1'b1; prescale = PW'(8);

    // reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_sampled_bit", 32'(sampled_bit), 32'd1);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    tick(); RST = 1'b1;
    repeat (3) tick();

    // P=8, line low before enable: first sample at edge 6 reads 0
    RX_IN = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    repeat (6) tick();
    @(negedge CLK);
    chk("p8_first_valid", 32'(sample_valid), 32'd1);
    chk("p8_first_bit", 32'(sampled_bit), 32'd0);
    tick(); enable = 1'b0; RX_IN = 1'b1;
    repeat (4) tick();

    // P=16, one-cycle glitch on the centre sample is voted out
    prescale = PW'(16); RX_IN = 1'b0;
    repeat (4) tick();
    for (int r = 0; r <= 10; r++) begin
      if (r > 0) tick();
      enable = 1'b1;
      RX_IN  = (r == 6);
      if (r == 10) begin
        @(negedge CLK);
        chk("p16_glitch_valid", 32'(sample_valid), 32'd1);
        chk("p16_glitch_bit", 32'(sampled_bit), 32'd0);
      end
    end
    tick(); enable = 1'b0; RX_IN = 1'b1;
    repeat (3) tick();

    // P=8 full frame: 11 samples, frame_done on cycle 87, bit_cnt back to 0
    prescale = PW'(8);
    tick();
    np = 0; nfd = 0; fd_r = -1;
    for (int r = 0; r < 88; r++) begin
      if (r > 0) tick();
      enable = 1'b1;
      RX_IN  = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (sample_valid) np++;
      if (frame_done) begin nfd++; fd_r = r; end
    end
    tick(); enable = 1'b0; RX_IN = 1'b1;
    @(negedge CLK);
    chk("frame_valid_count", 32'(np), 32'd11);
    chk("frame_done_count", 32'(nfd), 32'd1);
    chk("frame_done_cycle", 32'(fd_r), 32'd87);
    chk("frame_bit_cnt_wrap", 32'(bit_cnt), 32'd0);
    repeat (3) tick();

    // enable dropped at edge_cnt=2: counters clear, no sample
    for (int r = 0; r <= 8; r++) begin
      if (r > 0) tick();
      enable = (r < 2);
      RX_IN  = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (r == 2) chk("drop_edge_before", 32'(edge_cnt), 32'd2);
      if (r == 3) begin
        chk("drop_edge_after", 32'(edge_cnt), 32'd0);
        chk("drop_bit_after", 32'(bit_cnt), 32'd0);
      end
      if (r >= 2) chk("drop_no_valid", 32'(sample_valid), 32'd0);
    end
    RX_IN = 1'b1;

    // illegal prescale 12 behaves as P=8 and flags the error
    prescale = PW'(12);
    tick();
    nfd = 0;
    for (int r = 0; r < 88; r++) begin
      if (r > 0) tick();
      enable = 1'b1;
      RX_IN  = 1'($urandom_range(0, 1));
      @(negedge CLK);
      if (r == 40) chk("p12_prescale_err", 32'(prescale_err), 32'd1);
      if (frame_done) nfd = r;
    end
    chk("p12_frame_done_cycle", 32'(nfd), 32'd87);
    tick(); enable = 1'b0; RX_IN = 1'b1;
    repeat (3) tick();

    // randomized runs across legal and illegal ratios
    for (int k = 0; k < 6; k++) begin
      case ($urandom_range(0, 3))
        0:       prescale = PW'(8);
        1:       prescale = PW'(16);
        2:       prescale = PW'(32);
        default: prescale = PW'($urandom_range(0, 63));
      endcase
      pe  = eff_p(int'(prescale));
      len = $urandom_range(1, FB * pe + 10);
      lvl = 1'b1;
      tick();
      for (int r = 0; r < len; r++) begin
        if (r > 0) tick();
        enable = 1'b1;
        if ($urandom_range(0, 5) == 0) lvl = ~lvl;
        RX_IN = lvl;
      end
      tick(); enable = 1'b0; RX_IN = 1'b1;
      repeat ($urandom_range(1, 5)) tick();
    end

    // ratio shrinks from 32 to 8 with edge_cnt=20: wraps to 0 on the next edge
    prescale = PW'(32);
    tick();
    for (int r = 0; r <= 20; r++) begin
      if (r > 0) tick();
      enable = 1'b1;
      RX_IN  = 1'($urandom_range(0, 1));
      if (r == 20) begin
        prescale   = PW'(8);
        lock_phase = 1'b1;
      end
    end
    @(negedge CLK);
    chk("shrink_edge_before", 32'(edge_cnt), 32'd20);
    tick(); enable = 1'b0; RX_IN = 1'b1;
    @(negedge CLK);
    chk("shrink_edge_wrap", 32'(edge_cnt), 32'd0);
    chk("shrink_bit_step", 32'(bit_cnt), 32'd1);
    tick(); lock_phase = 1'b0;
    repeat (3) tick();

    // asynchronous reset at edge_cnt=5, bit_cnt=3
    prescale = PW'(8);
    tick();
    for (int r = 0; r <= 29; r++) begin
      if (r > 0) tick();
      enable = 1'b1;
      RX_IN  = 1'($urandom_range(0, 1));
    end
    chk("arst_pre_edge", 32'(edge_cnt), 32'd5);
    chk("arst_pre_bit", 32'(bit_cnt), 32'd3);
    #1 RST = 1'b0;
    #1;
    chk("arst_sampled_bit", 32'(sampled_bit), 32'd1);
    chk("arst_sample_valid", 32'(sample_valid), 32'd0);
    chk("arst_edge_cnt", 32'(edge_cnt), 32'd0);
    chk("arst_bit_cnt", 32'(bit_cnt), 32'd0);
    chk("arst_frame_done", 32'(frame_done), 32'd0);
    enable = 1'b0;
    tick(); tick(); RST = 1'b1; RX_IN = 1'b1;
    repeat (5) tick();

    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_sample_timer.md
RX_SAMPLE_TIMER -- requirements
Module: rx_sample_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 6, width of prescale input and edge counter.
REQ-002 SHALL have parameter FRAME_BITS, default 11, bit periods per frame (start + 8 data + parity + stop).
REQ-003 SHALL have port CLK  input  1  system oversampling clock; all state on rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_IN  input  1  raw asynchronous serial line, idle high.
REQ-006 SHALL have port prescale  input  PRESCALE_W  oversampling ratio; legal values 8, 16, 32.
REQ-007 SHALL have port enable  input  1  from RX FSM; counting and sampling active while high.
REQ-008 SHALL have port sampled_bit  output  1  majority-voted bit value, consumed by start/parity/stop checkers and deserializer.
REQ-009 SHALL have port sample_valid  output  1  one-cycle pulse marking a new sampled_bit.
REQ-010 SHALL have port edge_cnt  output  PRESCALE_W  current oversample edge within bit, 0..prescale-1.
REQ-011 SHALL have port bit_cnt  output  4  current bit index within frame, 0..FRAME_BITS-1.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse on final edge of last bit.
REQ-013 SHALL have port prescale_err  output  1  high while enable is high and prescale is not 8/16/32.

Function
REQ-014 SHALL pass RX_IN through a two-flop synchronizer (both flops reset to 1); all sampling uses the second flop (rx_s).
REQ-015 SHALL use effective prescale P = prescale when legal, else P = 8.
REQ-016 SHALL hold edge_cnt = 0 and bit_cnt = 0 while enable is low.
REQ-017 SHALL, while enable high, increment edge_cnt each cycle; edge_cnt = 0 in the first enabled cycle.
REQ-018 SHALL wrap edge_cnt from P-1 to 0 and increment bit_cnt on that same cycle.
REQ-019 SHALL wrap bit_cnt from FRAME_BITS-1 to 0 and pulse frame_done in the cycle where edge_cnt = P-1 and bit_cnt = FRAME_BITS-1.
REQ-020 SHALL capture rx_s into three sample registers at edge_cnt = P/2-1, P/2, P/2+1.
REQ-021 SHALL register sampled_bit = majority(s0,s1,s2) and pulse sample_valid in the cycle where edge_cnt = P/2+2 (one sample_valid per bit period).
REQ-022 SHALL hold sampled_bit at last value between valid pulses and while enable low.
REQ-023 SHALL, on enable falling mid-bit, clear counters and sample registers on the next edge and produce no sample_valid for the partial bit.
REQ-024 SHALL ignore prescale changes mid-frame only as far as P is recomputed combinationally; edge_cnt >= new P SHALL wrap to 0 on the next edge (no lock-up).
REQ-025 SHALL give sample_valid priority independent of frame_done; both may not coincide since P/2+2 < P-1 for P >= 8.

Reset
REQ-026 SHALL on RST low asynchronously set: synchronizer flops = 1, sample registers = 1, sampled_bit = 1, sample_valid = 0, edge_cnt = 0, bit_cnt = 0, frame_done = 0.
REQ-027 SHALL resume counting only on the first rising CLK after RST release with enable high.

Structure
REQ-028 SHALL place legal prescale constants (8, 16, 32), FRAME_BITS default and the majority function in shared package uart_rx_pkg.
REQ-029 SHALL implement the counters in one sub-module rx_edge_bit_counter; synchronizer and voter remain in top level.

Verification
REQ-030 SHALL test: P=8, RX_IN held 0 >=3 cycles before enable -> sample_valid in cycle 6 after enable, sampled_bit = 0.
REQ-031 SHALL test: P=16, RX_IN pulses 1 for one cycle landing on the P/2 sample, otherwise 0 -> sampled_bit = 0 (glitch voted out).
REQ-032 SHALL test: P=8, FRAME_BITS=11, enable held 88 cycles -> 11 sample_valid pulses, frame_done at cycle 87, bit_cnt back to 0.
REQ-033 SHALL test: enable dropped at edge_cnt = 2 -> no sample_valid, edge_cnt = 0 and bit_cnt = 0 next cycle.
REQ-034 SHALL test: prescale = 12 -> prescale_err = 1, behaviour identical to P=8.
REQ-035 SHALL test: RST asserted at edge_cnt = 5, bit_cnt = 3 -> all outputs at reset values immediately, without a clock edge.
